// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl: steps a 0..4 LED position code at a programmable rate under start/stop/hold buttons.
// Optional bounce (ping-pong) sequencing: define LED_SCAN_PINGPONG_EN; default build wraps using the dir input.
module led_scan_ctrl #(
    parameter int TICK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       dir,
    output logic [2:0] state,
    output logic       running,
    output logic       step
);
    localparam int            CW       = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]    r_start_sync;
    logic [1:0]    r_stop_sync;
    logic          r_start_prev;
    logic          r_stop_prev;
    logic [1:0]    r_fsm;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_pos;
    logic          r_running;
    logic          r_step;
    logic          w_start_edge;
    logic          w_stop_edge;
    logic [2:0]    w_next_pos;
`ifdef LED_SCAN_PINGPONG_EN
    logic          r_up;
    logic          w_next_up;
`else
    logic [1:0]    r_dir_sync;
`endif

    assign w_stop_edge  = r_stop_sync[1] & ~r_stop_prev;
    // Stop wins over a simultaneous start: the start edge is simply discarded.
    assign w_start_edge = r_start_sync[1] & ~r_start_prev & ~w_stop_edge;

    // Next position on an advance; out-of-range codes recover to 0.
    always_comb begin
        w_next_pos = 3'd0;
`ifdef LED_SCAN_PINGPONG_EN
        w_next_up = r_up;
        if (r_pos <= 3'd4) begin
            if (r_up) w_next_pos = (r_pos == 3'd4) ? 3'd3 : r_pos + 3'd1;
            else      w_next_pos = (r_pos == 3'd0) ? 3'd1 : r_pos - 3'd1;
        end
        if (w_next_pos == 3'd4)      w_next_up = 1'b0;
        else if (w_next_pos == 3'd0) w_next_up = 1'b1;
`else
        if (r_pos <= 3'd4) begin
            if (r_dir_sync[1]) w_next_pos = (r_pos == 3'd0) ? 3'd4 : r_pos - 3'd1;
            else               w_next_pos = (r_pos == 3'd4) ? 3'd0 : r_pos + 3'd1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_sync <= '0;
            r_stop_sync  <= '0;
            r_start_prev <= 1'b0;
            r_stop_prev  <= 1'b0;
            r_fsm        <= S_IDLE;
            r_cnt        <= '0;
            r_pos        <= 3'd0;
            r_running    <= 1'b0;
            r_step       <= 1'b0;
`ifdef LED_SCAN_PINGPONG_EN
            r_up         <= 1'b1;
`else
            r_dir_sync   <= '0;
`endif
        end else begin
            r_start_sync <= {r_start_sync[0], btn_start};
            r_stop_sync  <= {r_stop_sync[0], btn_stop};
            r_start_prev <= r_start_sync[1];
            r_stop_prev  <= r_stop_sync[1];
`ifndef LED_SCAN_PINGPONG_EN
            r_dir_sync   <= {r_dir_sync[0], dir};
`endif
            r_step <= 1'b0;
            case (r_fsm)
                S_IDLE: begin
                    if (w_start_edge) begin
                        r_fsm     <= S_RUN;
                        r_running <= 1'b1;
                        r_cnt     <= '0;
                        r_pos     <= 3'd0;
                    end
                end
                S_RUN: begin
                    // A stop coinciding with a prescaler wrap suppresses that advance.
                    if (w_stop_edge) begin
                        r_fsm     <= S_HOLD;
                        r_running <= 1'b0;
                        if (r_pos > 3'd4) r_pos <= 3'd0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_cnt  <= '0;
                        r_pos  <= w_next_pos;
                        r_step <= 1'b1;
`ifdef LED_SCAN_PINGPONG_EN
                        r_up   <= w_next_up;
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_stop_edge) begin
                        r_fsm <= S_IDLE;
                        r_pos <= 3'd0;
`ifdef LED_SCAN_PINGPONG_EN
                        r_up  <= 1'b1;
`endif
                    end else if (w_start_edge) begin
                        r_fsm     <= S_RUN;
                        r_running <= 1'b1;
                        r_cnt     <= '0;
                        if (r_pos > 3'd4) r_pos <= 3'd0;
                    end
                end
                default: begin
                    r_fsm     <= S_IDLE;
                    r_pos     <= 3'd0;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    assign state   = r_pos;
    assign running = r_running;
    assign step    = r_step;
endmodule

// File: tb/tb_led_scan_ctrl.sv
// Self-checking bench for led_scan_ctrl (TICK_DIV=4) against a position/sequence model.
// Model follows the bounce sequence when LED_SCAN_PINGPONG_EN is defined.
module tb_led_scan_ctrl;
    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_stop = 1'b0;
    logic       dir = 1'b0;
    logic [2:0] state;
    logic       running;
    logic       step;

    int n_checks = 0;
    int n_pass   = 0;

    int m_pos   = 0;
    int m_phase = 0;
    int m_run_t = 0;
    int bounce_seq [8] = '{0, 1, 2, 3, 4, 3, 2, 1};

    led_scan_ctrl #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_stop(btn_stop),
        .dir(dir), .state(state), .running(running), .step(step)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_adv();
`ifdef LED_SCAN_PINGPONG_EN
        m_phase = (m_phase + 1) % 8;
        m_pos   = bounce_seq[m_phase];
`else
        m_pos = dir ? (m_pos + 4) % 5 : (m_pos + 1) % 5;
`endif
    endtask

    task automatic model_clear();
        m_pos   = 0;
        m_phase = 0;
        m_run_t = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        btn_start = 1'b0;
        btn_stop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
        repeat (3) tick();
    endtask

    // Cycles in RUN: an advance every TD cycles after RUN entry.
    task automatic run_segment(input int n);
        logic exp_step;
        for (int i = 0; i < n; i++) begin
`ifdef LED_SCAN_PINGPONG_EN
            dir = 1'($urandom_range(0, 1));
`endif
            tick();
            m_run_t++;
            exp_step = (m_run_t % TD == 0);
            if (exp_step) model_adv();
            n_checks++;
            if (state !== 3'(m_pos) || step !== exp_step || running !== 1'b1)
                $display("FAIL run t=%0t state=%0d step=%0b running=%0b want state=%0d step=%0b running=1",
                         $time, state, step, running, m_pos, exp_step);
            else n_pass++;
        end
    endtask

    task automatic run_until(input int pos);
        for (int k = 0; k < 100 && m_pos != pos; k++) run_segment(1);
    endtask

    task automatic hold_segment(input int n);
        for (int i = 0; i < n; i++) begin
`ifdef LED_SCAN_PINGPONG_EN
            dir = 1'($urandom_range(0, 1));
`endif
            tick();
            n_checks++;
            if (state !== 3'(m_pos) || step !== 1'b0 || running !== 1'b0)
                $display("FAIL hold t=%0t state=%0d step=%0b running=%0b want state=%0d step=0 running=0",
                         $time, state, step, running, m_pos);
            else n_pass++;
        end
    endtask

    task automatic press_start();
        btn_start = 1'b1;
        tick();
        btn_start = 1'b0;
        tick();
        n_checks++;
        if (running !== 1'b0) $display("FAIL start_latency_e1 running=%0b want 0", running);
        else n_pass++;
        tick();
        n_checks++;
        if (running !== 1'b1 || state !== 3'(m_pos) || step !== 1'b0)
            $display("FAIL start_latency_e2 running=%0b state=%0d step=%0b want running=1 state=%0d step=0",
                     running, state, step, m_pos);
        else n_pass++;
        m_run_t = 0;
    endtask

    task automatic press_stop_run();
        btn_stop = 1'b1;
        run_segment(1);
        btn_stop = 1'b0;
        run_segment(1);
        tick();
        n_checks++;
        if (running !== 1'b0 || step !== 1'b0 || state !== 3'(m_pos))
            $display("FAIL stop_to_hold running=%0b step=%0b state=%0d want running=0 step=0 state=%0d",
                     running, step, state, m_pos);
        else n_pass++;
    endtask

    task automatic press_stop_hold();
        btn_stop = 1'b1;
        tick();
        btn_stop = 1'b0;
        tick();
        tick();
        model_clear();
        n_checks++;
        if (running !== 1'b0 || step !== 1'b0 || state !== 3'd0)
            $display("FAIL hold_to_idle running=%0b step=%0b state=%0d want 0 0 0", running, step, state);
        else n_pass++;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (state !== 3'd0 || running !== 1'b0 || step !== 1'b0)
            $display("FAIL reset_values state=%0d running=%0b step=%0b want 0 0 0", state, running, step);
        else n_pass++;
        dir = 1'b0;
        press_start();
        run_until(3);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (state !== 3'd0 || running !== 1'b0 || step !== 1'b0)
            $display("FAIL async_reset state=%0d running=%0b step=%0b want 0 0 0", state, running, step);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
        hold_segment(8);
    endtask

    task automatic test_wrap_up();
        do_reset();
        dir = 1'b0;
        repeat (3) tick();
        press_start();
        run_segment(6 * TD + $urandom_range(0, 3));
        press_stop_run();
        press_stop_hold();
    endtask

    task automatic test_hold_resume();
        do_reset();
        dir = 1'b0;
        press_start();
        run_until(2);
        press_stop_run();
        hold_segment(20 + $urandom_range(0, 10));
        press_start();
        run_segment(TD);
        n_checks++;
        if (state !== 3'd3) $display("FAIL resume_first_advance state=%0d want 3", state);
        else n_pass++;
        press_stop_run();
        press_stop_hold();
        hold_segment(5);
    endtask

    task automatic test_wrap_down();
        do_reset();
        dir = 1'b1;
        repeat (3) tick();
        press_start();
        run_segment(6 * TD + $urandom_range(0, 3));
        press_stop_run();
        press_stop_hold();
        dir = 1'b0;
    endtask

    task automatic test_simultaneous();
        do_reset();
        btn_start = 1'b1;
        btn_stop  = 1'b1;
        tick();
        btn_start = 1'b0;
        btn_stop  = 1'b0;
        hold_segment(6);
        dir = 1'b0;
        press_start();
        run_until(3);
        press_stop_run();
        n_checks++;
        if (state !== 3'd3) $display("FAIL simul_setup state=%0d want 3", state);
        else n_pass++;
        btn_start = 1'b1;
        btn_stop  = 1'b1;
        tick();
        btn_start = 1'b0;
        btn_stop  = 1'b0;
        tick();
        tick();
        model_clear();
        hold_segment(6);
    endtask

    task automatic test_random();
        do_reset();
        for (int it = 0; it < 8; it++) begin
            dir = 1'($urandom_range(0, 1));
            hold_segment(3);
            press_start();
            run_segment($urandom_range(3, 30));
            press_stop_run();
            hold_segment($urandom_range(2, 20));
            if ($urandom_range(0, 1) == 1) press_stop_hold();
        end
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_hold_resume();
        test_wrap_down();
        test_simultaneous();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
